// File: rtl/jk_pkg.sv
// Shared definitions for the JK-flip-flop based counter family: the JK
// command encoding and the helper that derives a cell's J/K pair from the
// bit's current and desired next value.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_e;

    // Returns {J,K}. Only the set, reset and hold codes can come out of this,
    // so a cell is never driven through the toggle code.
    function automatic logic [1:0] jk_drive(input logic cur, input logic nxt);
        return {nxt & ~cur, ~nxt & cur};
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single edge-triggered JK flip-flop with asynchronous active-low clear.
// This is the storage primitive for each bit of the counter.
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_n
);

    // Apply the JK command on each rising edge; clear whenever reset is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:  q <= q;
                JK_RESET: q <= 1'b0;
                JK_SET:   q <= 1'b1;
                default:  q <= ~q;
            endcase
        end
    end

    assign q_n = ~q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter. The count lives in WIDTH
// JK cells; this module computes the next count (load > count > hold),
// converts it into per-cell J/K commands, and produces the terminal-count
// flag and the registered wrap pulse.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             tc,
    output logic             wrap_pulse
);

    // Refuse to elaborate with an unusable width/modulus combination.
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("jk_sync_counter: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_sync_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    // One extra bit so that reaching MODULUS going up and borrowing below
    // zero going down are both visible without any special cases.
    assign count_ext    = {1'b0, count};
    assign sum          = count_ext + (WIDTH+1)'(1);
    assign diff         = count_ext - (WIDTH+1)'(1);
    assign load_ext     = {1'b0, load_val};
    assign load_clamped = (load_ext >= MOD_EXT) ? MAX_COUNT : load_val;

    // Next-count selection: load beats enable, and enable with the count at
    // the end of the range in the current direction wraps around.
    always_comb begin
        nxt      = count;
        wrap_nxt = 1'b0;
        if (load) begin
            nxt = load_clamped;
        end else if (en) begin
            if (up) begin
                if (sum == MOD_EXT) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = sum[WIDTH-1:0];
                end
            end else begin
                if (diff[WIDTH]) begin
                    nxt      = MAX_COUNT;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = diff[WIDTH-1:0];
                end
            end
        end
    end

    // One JK cell per bit, driven with set/reset/hold toward the next count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {j_vec[i], k_vec[i]} = jk_drive(count[i], nxt[i]);

        jk_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (count[i]),
            .q_n   (count_n[i])
        );
    end

    assign tc = up ? (count == MAX_COUNT) : (count == '0);

    // Wrap pulse lines up with the wrapped count, so it is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Testbench for jk_sync_counter: a decimal instance (WIDTH=4, MODULUS=10)
// and a full-binary instance (WIDTH=4, MODULUS=16), both checked against a
// modular-arithmetic reference model.
module tb_jk_sync_counter;

    localparam int W  = 4;
    localparam int MA = 10;
    localparam int MB = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         en_a = 1'b0, up_a = 1'b0, load_a = 1'b0;
    logic [W-1:0] lv_a = '0;
    logic [W-1:0] count_a, count_n_a;
    logic         tc_a, wrap_a;

    logic         en_b = 1'b0, up_b = 1'b0, load_b = 1'b0;
    logic [W-1:0] lv_b = '0;
    logic [W-1:0] count_b, count_n_b;
    logic         tc_b, wrap_b;

    int vectors = 0;
    int miscompares = 0;

    int ma_count = 0;
    int mb_count = 0;
    bit ma_wrap = 1'b0;
    bit mb_wrap = 1'b0;

    jk_sync_counter #(.WIDTH(W), .MODULUS(MA)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_a),
        .up         (up_a),
        .load       (load_a),
        .load_val   (lv_a),
        .count      (count_a),
        .count_n    (count_n_a),
        .tc         (tc_a),
        .wrap_pulse (wrap_a)
    );

    jk_sync_counter #(.WIDTH(W), .MODULUS(MB)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_b),
        .up         (up_b),
        .load       (load_b),
        .load_val   (lv_b),
        .count      (count_b),
        .count_n    (count_n_b),
        .tc         (tc_b),
        .wrap_pulse (wrap_b)
    );

    always #5 clk = ~clk;

    // Reference behaviour: modular arithmetic on plain integers.
    function automatic int model_next(input int cur, input int modulus, input bit e,
                                      input bit u, input bit l, input int lv,
                                      output bit wrap);
        wrap = 1'b0;
        if (l) return (lv < modulus) ? lv : modulus - 1;
        if (!e) return cur;
        if (u) begin
            if (cur == modulus - 1) wrap = 1'b1;
            return (cur + 1) % modulus;
        end
        if (cur == 0) wrap = 1'b1;
        return (cur + modulus - 1) % modulus;
    endfunction

    // One clock on instance A (B held); ends 1 time unit after the edge.
    task automatic step_a(input bit e, input bit u, input bit l, input int lv);
        en_a = e; up_a = u; load_a = l; lv_a = W'(lv);
        en_b = 1'b0; load_b = 1'b0;
        ma_count = model_next(ma_count, MA, e, u, l, lv, ma_wrap);
        mb_count = model_next(mb_count, MB, 1'b0, up_b, 1'b0, 0, mb_wrap);
        @(posedge clk);
        #1;
    endtask

    // One clock on instance B (A held).
    task automatic step_b(input bit e, input bit u, input bit l, input int lv);
        en_b = e; up_b = u; load_b = l; lv_b = W'(lv);
        en_a = 1'b0; load_a = 1'b0;
        mb_count = model_next(mb_count, MB, e, u, l, lv, mb_wrap);
        ma_count = model_next(ma_count, MA, 1'b0, up_a, 1'b0, 0, ma_wrap);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (count_a !== '0 || count_n_a !== '1 || wrap_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_a: count=%0d count_n=%h wrap=%b, expected 0/f/0",
                     count_a, count_n_a, wrap_a);
        end
        vectors++;
        if (count_b !== '0 || count_n_b !== '1 || wrap_b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_b: count=%0d count_n=%h wrap=%b, expected 0/f/0",
                     count_b, count_n_b, wrap_b);
        end
        ma_count = 0; mb_count = 0; ma_wrap = 1'b0; mb_wrap = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_up_count();
        for (int i = 0; i < 10; i++) begin
            up_a = 1'b1;
            #1;
            vectors++;
            if (count_a !== W'(ma_count) || tc_a !== (ma_count == MA - 1)) begin
                miscompares++;
                $display("[TB] FAIL up_count step %0d: count=%0d tc=%b, expected %0d tc=%b",
                         i, count_a, tc_a, ma_count, (ma_count == MA - 1));
            end
            step_a(1'b1, 1'b1, 1'b0, 0);
        end
        vectors++;
        if (count_a !== W'(ma_count) || wrap_a !== ma_wrap) begin
            miscompares++;
            $display("[TB] FAIL up_wrap: count=%0d wrap=%b, expected %0d wrap=%b",
                     count_a, wrap_a, ma_count, ma_wrap);
        end
        step_a(1'b1, 1'b1, 1'b0, 0);
        vectors++;
        if (count_a !== W'(ma_count) || wrap_a !== ma_wrap) begin
            miscompares++;
            $display("[TB] FAIL up_after_wrap: count=%0d wrap=%b, expected %0d wrap=%b",
                     count_a, wrap_a, ma_count, ma_wrap);
        end
    endtask

    task automatic test_down_wrap();
        step_a(1'b0, 1'b0, 1'b1, 0);
        vectors++;
        if (count_a !== '0 || tc_a !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL down_tc: count=%0d tc=%b, expected 0 tc=1", count_a, tc_a);
        end
        for (int i = 0; i < 2; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 0);
            vectors++;
            if (count_a !== W'(ma_count) || wrap_a !== ma_wrap) begin
                miscompares++;
                $display("[TB] FAIL down_wrap step %0d: count=%0d wrap=%b, expected %0d wrap=%b",
                         i, count_a, wrap_a, ma_count, ma_wrap);
            end
        end
    endtask

    task automatic test_load();
        int lvs[3] = '{5, 13, 2};
        bit ens[3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step_a(ens[i], 1'b1, 1'b1, lvs[i]);
            vectors++;
            if (count_a !== W'(ma_count) || wrap_a !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL load val=%0d: count=%0d wrap=%b, expected %0d wrap=0",
                         lvs[i], count_a, wrap_a, ma_count);
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] six = W'(6);
        step_a(1'b0, 1'b1, 1'b1, 6);
        for (int i = 0; i < 20; i++) begin
            step_a(1'b0, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 15)));
            vectors++;
            if (count_a !== six || count_n_a !== ~six || wrap_a !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold cycle %0d: count=%0d count_n=%h wrap=%b, expected 6/%h/0",
                         i, count_a, count_n_a, wrap_a, ~six);
            end
        end
    endtask

    task automatic test_async_reset();
        int preload[2] = '{9, 7};
        for (int s = 0; s < 2; s++) begin
            step_a(1'b0, 1'b1, 1'b1, preload[s]);
            if (s == 0) step_a(1'b1, 1'b1, 1'b0, 0);
            #2;
            rst_n = 1'b0;
            #1;
            vectors++;
            if (count_a !== '0 || count_n_a !== '1 || wrap_a !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL async_reset %0d: count=%0d count_n=%h wrap=%b, expected 0/f/0",
                         s, count_a, count_n_a, wrap_a);
            end
            ma_count = 0; mb_count = 0; ma_wrap = 1'b0; mb_wrap = 1'b0;
            rst_n = 1'b1;
            step_a(1'b1, 1'b1, 1'b0, 0);
            vectors++;
            if (count_a !== W'(1) || wrap_a !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_release %0d: count=%0d wrap=%b, expected 1 wrap=0",
                         s, count_a, wrap_a);
            end
        end
    endtask

    task automatic test_random();
        bit e, u, l;
        int lv;
        logic [W-1:0] exp_count;
        for (int i = 0; i < 300; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 7) == 0);
            lv = int'($urandom_range(0, 15));
            step_a(e, u, l, lv);
            exp_count = W'(ma_count);
            vectors++;
            if (count_a !== exp_count || count_n_a !== ~exp_count || wrap_a !== ma_wrap
                || tc_a !== (u ? (ma_count == MA - 1) : (ma_count == 0))) begin
                miscompares++;
                $display("[TB] FAIL random %0d: count=%0d count_n=%h wrap=%b tc=%b, expected %0d wrap=%b",
                         i, count_a, count_n_a, wrap_a, tc_a, ma_count, ma_wrap);
            end
        end
    endtask

    task automatic test_full_binary();
        bit dirs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bit ens[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bit lds[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int lvs[6]  = '{15, 0, 0, 3, 0, 0};
        step_b(1'b0, 1'b1, 1'b1, 15);
        vectors++;
        if (count_b !== W'(15) || tc_b !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL binary_tc: count=%0d tc=%b, expected 15 tc=1", count_b, tc_b);
        end
        for (int i = 1; i < 6; i++) begin
            step_b(ens[i], dirs[i], lds[i], lvs[i]);
            vectors++;
            if (count_b !== W'(mb_count) || wrap_b !== mb_wrap) begin
                miscompares++;
                $display("[TB] FAIL binary step %0d: count=%0d wrap=%b, expected %0d wrap=%b",
                         i, count_b, wrap_b, mb_count, mb_wrap);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step_b(1'b1, (i % 2 == 0), 1'b0, 0);
            vectors++;
            if (count_b !== W'(mb_count) || wrap_b !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL binary_oscillate %0d: count=%0d wrap=%b, expected %0d wrap=0",
                         i, count_b, wrap_b, mb_count);
            end
        end
    endtask

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load();
        test_hold();
        test_async_reset();
        test_random();
        test_full_binary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
